ddr3_cpu_arbiter: RTL and testbench

DDR3_CPU_ARBITER -- requirements
Module: ddr3_cpu_arbiter

---
 rtl/ddr3_pkg.sv | 27 ++
 rtl/ddr3_rr_arbiter.sv | 33 +++
 rtl/ddr3_cpu_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_ddr3_cpu_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// Shared FSM encoding, limits and index helpers
// for the DDR3 CPU-port arbiter.
package ddr3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_WAIT_WR = 2'd3
  } state_e;

  localparam int PORTS_MIN = 2;
  localparam int PORTS_MAX = 8;
  localparam int TMO_MIN   = 1;
  localparam int TMO_MAX   = 65535;
  localparam int CNT_W     = 16;
  localparam int IDX_W     = 3;

  // Port index increment that wraps at n-1.
  function automatic logic [IDX_W-1:0] wrap_inc(
    input logic [IDX_W-1:0] v,
    input int               n
  );
    return (int'(v) == n - 1) ? '0 : v + 3'd1;
  endfunction

endpackage

// File: rtl/ddr3_rr_arbiter.sv
// Round-robin priority search starting at ptr_i;
// returns a one-hot grant and its index.
module ddr3_rr_arbiter
  import ddr3_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int p;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    p     = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(ptr_i) + k;
      if (p >= N) p = p - N;
      if (!any_o && req_i[p]) begin
        any_o    = 1'b1;
        gnt_o[p] = 1'b1;
        idx_o    = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/ddr3_cpu_arbiter.sv
// Multi-port CPU front end for one DDR3 controller:
// round-robin grant, one request in flight, timeout.
module ddr3_cpu_arbiter
  import ddr3_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 15,
  parameter int TIMEOUT   = 255
) (
  input  logic                 CPU_CLK,
  input  logic                 RESET_N,
  input  logic [NUM_PORTS-1:0] P_ADDR_VALID,
  input  logic [NUM_PORTS-1:0] P_CMD,
  input  logic [NUM_PORTS-1:0][2:0]          P_BA,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]   P_ADDR,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]   P_WR_DATA,
  input  logic [NUM_PORTS-1:0][DATA_W/8-1:0] P_DM,
  output logic [NUM_PORTS-1:0] P_CMD_RDY,
  output logic [NUM_PORTS-1:0] P_RD_DATA_VALID,
  output logic [NUM_PORTS-1:0] P_WR_DATA_VALID,
  output logic [DATA_W-1:0]    P_RD_DATA,
  output logic                 C_ADDR_VALID,
  output logic                 C_CMD,
  output logic [2:0]           C_BA,
  output logic [ADDR_W-1:0]    C_ADDR,
  output logic [DATA_W-1:0]    C_WR_DATA,
  output logic [DATA_W/8-1:0]  C_DM,
  input  logic                 C_CMD_RDY,
  input  logic                 C_RD_DATA_VALID,
  input  logic                 C_WR_DATA_VALID,
  input  logic [DATA_W-1:0]    C_RD_DATA,
  output logic                 ERR,
  output logic [2:0]           ERR_PORT
);

  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       own_q, own_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [2:0]             errp_q, errp_d;
  logic                   cmd_q, cmd_d;
  logic [2:0]             ba_q, ba_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wd_q, wd_d;
  logic [DATA_W/8-1:0]    dm_q, dm_d;
  logic [DATA_W-1:0]      rdd_q, rdd_d;
  logic [NUM_PORTS-1:0]   rdy_q, rdy_d;
  logic [NUM_PORTS-1:0]   rdv_q, rdv_d;
  logic [NUM_PORTS-1:0]   wrv_q, wrv_d;

  logic [NUM_PORTS-1:0]   gnt;
  logic [IDX_W-1:0]       idx;
  logic                   any;
  logic [NUM_PORTS-1:0]   own_oh;
  logic                   fin;

  logic                   g_cmd;
  logic [2:0]             g_ba;
  logic [ADDR_W-1:0]      g_addr;
  logic [DATA_W-1:0]      g_wd;
  logic [DATA_W/8-1:0]    g_dm;

  ddr3_rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req_i (P_ADDR_VALID),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (idx),
    .any_o (any)
  );

  always_comb begin
    g_cmd  = 1'b0;
    g_ba   = '0;
    g_addr = '0;
    g_wd   = '0;
    g_dm   = '0;
    own_oh = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      own_oh[k] = (own_q == IDX_W'(k));
      if (gnt[k]) begin
        g_cmd  = P_CMD[k];
        g_ba   = P_BA[k];
        g_addr = P_ADDR[k];
        g_wd   = P_WR_DATA[k];
        g_dm   = P_DM[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    errp_d  = errp_q;
    cmd_d   = cmd_q;
    ba_d    = ba_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    dm_d    = dm_q;
    rdd_d   = rdd_q;
    rdy_d   = '0;
    rdv_d   = '0;
    wrv_d   = '0;
    fin     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          state_d = ST_ISSUE;
          own_d   = idx;
          rdy_d   = gnt;
          cmd_d   = g_cmd;
          ba_d    = g_ba;
          addr_d  = g_addr;
          wd_d    = g_wd;
          dm_d    = g_dm;
        end
      end
      ST_ISSUE: begin
        if (C_CMD_RDY) begin
          state_d = cmd_q ? ST_WAIT_RD : ST_WAIT_WR;
          cnt_d   = '0;
        end
      end
      ST_WAIT_RD: begin
        if (C_RD_DATA_VALID) begin
          rdd_d = C_RD_DATA;
          rdv_d = own_oh;
          fin   = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          err_d  = 1'b1;
          errp_d = own_q;
          fin    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_WR: begin
        // completion wins over a same-cycle timeout
        if (C_WR_DATA_VALID) begin
          wrv_d = own_oh;
          fin   = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          err_d  = 1'b1;
          errp_d = own_q;
          fin    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fin) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ptr_d   = wrap_inc(own_q, NUM_PORTS);
    end
  end

  always_ff @(posedge CPU_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      errp_q  <= '0;
      cmd_q   <= 1'b0;
      ba_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      dm_q    <= '0;
      rdd_q   <= '0;
      rdy_q   <= '0;
      rdv_q   <= '0;
      wrv_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      errp_q  <= errp_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      dm_q    <= dm_d;
      rdd_q   <= rdd_d;
      rdy_q   <= rdy_d;
      rdv_q   <= rdv_d;
      wrv_q   <= wrv_d;
    end
  end

  assign P_CMD_RDY       = rdy_q;
  assign P_RD_DATA_VALID = rdv_q;
  assign P_WR_DATA_VALID = wrv_q;
  assign P_RD_DATA       = rdd_q;
  assign C_ADDR_VALID    = (state_q == ST_ISSUE);
  assign C_CMD           = cmd_q;
  assign C_BA            = ba_q;
  assign C_ADDR          = addr_q;
  assign C_WR_DATA       = wd_q;
  assign C_DM            = dm_q;
  assign ERR             = err_q;
  assign ERR_PORT        = errp_q;

endmodule

// File: tb/tb_ddr3_cpu_arbiter.sv
// Directed bench for ddr3_cpu_arbiter with
// TIMEOUT=4 and four 64-bit ports.
module tb_ddr3_cpu_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int AW = 15;
  localparam int TO = 4;

  logic                    clk;
  logic                    rst_n;
  logic [NP-1:0]           p_av;
  logic [NP-1:0]           p_cmd;
  logic [NP-1:0][2:0]      p_ba;
  logic [NP-1:0][AW-1:0]   p_addr;
  logic [NP-1:0][DW-1:0]   p_wd;
  logic [NP-1:0][DW/8-1:0] p_dm;
  logic [NP-1:0]           p_rdy;
  logic [NP-1:0]           p_rdv;
  logic [NP-1:0]           p_wrv;
  logic [DW-1:0]           p_rdd;
  logic                    c_av;
  logic                    c_cmd;
  logic [2:0]              c_ba;
  logic [AW-1:0]           c_addr;
  logic [DW-1:0]           c_wd;
  logic [DW/8-1:0]         c_dm;
  logic                    c_rdy;
  logic                    c_rdv;
  logic                    c_wrv;
  logic [DW-1:0]           c_rdd;
  logic                    err;
  logic [2:0]              err_port;

  int n_cmp;
  int n_bad;

  ddr3_cpu_arbiter #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .TIMEOUT   (TO)
  ) dut (
    .CPU_CLK         (clk),
    .RESET_N         (rst_n),
    .P_ADDR_VALID    (p_av),
    .P_CMD           (p_cmd),
    .P_BA            (p_ba),
    .P_ADDR          (p_addr),
    .P_WR_DATA       (p_wd),
    .P_DM            (p_dm),
    .P_CMD_RDY       (p_rdy),
    .P_RD_DATA_VALID (p_rdv),
    .P_WR_DATA_VALID (p_wrv),
    .P_RD_DATA       (p_rdd),
    .C_ADDR_VALID    (c_av),
    .C_CMD           (c_cmd),
    .C_BA            (c_ba),
    .C_ADDR          (c_addr),
    .C_WR_DATA       (c_wd),
    .C_DM            (c_dm),
    .C_CMD_RDY       (c_rdy),
    .C_RD_DATA_VALID (c_rdv),
    .C_WR_DATA_VALID (c_wrv),
    .C_RD_DATA       (c_rdd),
    .ERR             (err),
    .ERR_PORT        (err_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    int w;
    int e;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    p_av  = '0;
    p_cmd = '0;
    c_rdy = 1'b0;
    c_rdv = 1'b0;
    c_wrv = 1'b0;
    c_rdd = '0;
    for (int k = 0; k < NP; k++) begin
      p_ba[k]   = 3'(k);
      p_addr[k] = AW'(256 + k);
      p_wd[k]   = 64'h1111_1111_1111_1111 * 64'(k + 1);
      p_dm[k]   = 8'(8'h10 + k);
    end

    // reset state, even with a request pending
    p_av[0] = 1'b1;
    tick();
    tick();
    chk("rst_rdy",   64'(p_rdy),    64'h0);
    chk("rst_cav",   64'(c_av),     64'h0);
    chk("rst_err",   64'(err),      64'h0);
    chk("rst_errp",  64'(err_port), 64'h0);
    chk("rst_rdd",   p_rdd,         64'h0);
    chk("rst_caddr", 64'(c_addr),   64'h0);

    // ports 0 and 2 read together
    rst_n = 1'b1;
    p_av  = 4'b0101;
    p_cmd = 4'b0101;
    tick();
    chk("g0_rdy",   64'(p_rdy),  64'h1);
    chk("g0_cav",   64'(c_av),   64'h1);
    chk("g0_ccmd",  64'(c_cmd),  64'h1);
    chk("g0_caddr", 64'(c_addr), 64'h100);
    p_av[0] = 1'b0;
    c_rdy   = 1'b1;
    tick();
    chk("g0_rdy_off", 64'(p_rdy), 64'h0);
    chk("g0_cav_off", 64'(c_av),  64'h0);
    c_rdy = 1'b0;
    c_rdv = 1'b1;
    c_rdd = 64'hA5A5_A5A5_A5A5_A5A5;
    tick();
    chk("r0_vld",  64'(p_rdv), 64'h1);
    chk("r0_data", p_rdd,      64'hA5A5_A5A5_A5A5_A5A5);
    chk("r0_rdy",  64'(p_rdy), 64'h0);
    c_rdv = 1'b0;
    tick();
    chk("g2_rdy",   64'(p_rdy),  64'h4);
    chk("g2_caddr", 64'(c_addr), 64'h102);
    chk("g2_cba",   64'(c_ba),   64'h2);
    chk("g2_rdv",   64'(p_rdv),  64'h0);
    chk("g2_hold",  p_rdd,       64'hA5A5_A5A5_A5A5_A5A5);
    p_av[2] = 1'b0;
    c_rdy   = 1'b1;
    tick();
    c_rdy = 1'b0;
    // completion on the 4th wait cycle is still success
    tick();
    tick();
    tick();
    c_rdv = 1'b1;
    c_rdd = 64'h5A5A_5A5A_5A5A_5A5A;
    tick();
    chk("r2_vld",  64'(p_rdv), 64'h4);
    chk("r2_data", p_rdd,      64'h5A5A_5A5A_5A5A_5A5A);
    chk("r2_err",  64'(err),   64'h0);

    // stray completions while idle
    c_rdd = 64'hDEAD_BEEF_DEAD_BEEF;
    c_wrv = 1'b1;
    tick();
    chk("stray_rdv",  64'(p_rdv), 64'h0);
    chk("stray_wrv",  64'(p_wrv), 64'h0);
    chk("stray_data", p_rdd,      64'h5A5A_5A5A_5A5A_5A5A);
    c_rdv = 1'b0;
    c_wrv = 1'b0;

    // port 3 write, controller stalls 5 cycles
    p_av  = 4'b1000;
    p_cmd = 4'b0000;
    tick();
    chk("g3_rdy", 64'(p_rdy), 64'h8);
    p_av = '0;
    for (int i = 0; i < 6; i++) begin
      chk("w3_cav",   64'(c_av),   64'h1);
      chk("w3_ccmd",  64'(c_cmd),  64'h0);
      chk("w3_caddr", 64'(c_addr), 64'h103);
      chk("w3_cwd",   c_wd,        64'h4444_4444_4444_4444);
      chk("w3_cdm",   64'(c_dm),   64'h13);
      if (i == 5) c_rdy = 1'b1;
      tick();
    end
    chk("w3_cav_off", 64'(c_av), 64'h0);
    c_rdy = 1'b0;
    tick();
    chk("w3_early", 64'(p_wrv), 64'h0);
    c_wrv = 1'b1;
    tick();
    chk("w3_wrv", 64'(p_wrv), 64'h8);
    c_wrv = 1'b0;
    tick();
    chk("w3_wrv_off", 64'(p_wrv), 64'h0);

    // all ports requesting continuously
    p_av  = 4'b1111;
    p_cmd = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      e = i % NP;
      w = 0;
      while (p_rdy == '0 && w < 8) begin
        tick();
        w++;
      end
      chk("rr_grant", 64'(p_rdy), 64'(1 << e));
      c_rdy = 1'b1;
      tick();
      c_rdy = 1'b0;
      c_rdv = 1'b1;
      c_rdd = 64'hC0DE_0000_0000_0000 + 64'(i);
      tick();
      chk("rr_rdv", 64'(p_rdv), 64'(1 << e));
      chk("rr_rdd", p_rdd,
          64'hC0DE_0000_0000_0000 + 64'(i));
      c_rdv = 1'b0;
    end
    p_av = '0;
    tick();

    // port 1 read that never completes
    p_av  = 4'b0010;
    p_cmd = 4'b0010;
    tick();
    chk("t1_rdy", 64'(p_rdy), 64'h2);
    p_av  = '0;
    c_rdy = 1'b1;
    tick();
    c_rdy = 1'b0;
    tick();
    tick();
    tick();
    chk("t1_err_pre", 64'(err), 64'h0);
    tick();
    chk("t1_err",  64'(err),      64'h1);
    chk("t1_errp", 64'(err_port), 64'h1);
    chk("t1_rdv",  64'(p_rdv),    64'h0);
    tick();
    chk("t1_rdv2", 64'(p_rdv),    64'h0);

    // next request is still served; reset during WAIT_WR
    p_av  = 4'b0100;
    p_cmd = 4'b0000;
    tick();
    chk("t2_rdy",    64'(p_rdy), 64'h4);
    chk("t2_sticky", 64'(err),   64'h1);
    p_av  = '0;
    c_rdy = 1'b1;
    tick();
    c_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ar_cav",   64'(c_av),     64'h0);
    chk("ar_err",   64'(err),      64'h0);
    chk("ar_errp",  64'(err_port), 64'h0);
    chk("ar_rdd",   p_rdd,         64'h0);
    chk("ar_caddr", 64'(c_addr),   64'h0);
    chk("ar_cwd",   c_wd,          64'h0);
    c_wrv = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_wrv",  64'(p_wrv), 64'h0);
    chk("ar_rdy",  64'(p_rdy), 64'h0);
    c_wrv = 1'b0;
    tick();
    chk("ar_wrv2", 64'(p_wrv), 64'h0);

    // pointer restarts at port 0 after reset
    p_av  = 4'b0101;
    p_cmd = 4'b0101;
    tick();
    chk("ptr_rst", 64'(p_rdy), 64'h1);
    p_av = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
